// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier state encoding, latency and the opcodes
// the ALU top-level mux uses to pick the low or high product half.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_LATENCY = MUL_WIDTH + 1;

  // MUL selects product[31:0], MULH selects product[63:32]
  localparam logic [3:0] ALU_OP_MUL  = 4'd8;
  localparam logic [3:0] ALU_OP_MULH = 4'd9;

endpackage

// File: rtl/mult_32bit_seq_if.sv
// Start/done bundle of the sequential multiplier. Handshake: start is taken
// on a rising edge only while ready=1; done pulses for one cycle when product is valid.
interface mult_32bit_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);
endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath: multiplicand register, {upper, multiplier} accumulator,
// the (WIDTH+1)-bit adder and the right shifter.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] step_val
);

  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   upper;

  // Add keeps its carry in bit WIDTH; the shift below pulls it back into range.
  always_comb begin
    upper = acc[2*WIDTH:WIDTH];
    if (acc[0]) upper = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    step_val = {upper, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= {{(WIDTH+1){1'b0}}, b};
    end else if (step) begin
      acc <= {1'b0, step_val};
    end
  end

endmodule

// File: rtl/mult_32bit_seq.sv
// Sequential unsigned WIDTHxWIDTH multiplier: one multiplier bit per clock,
// product registered on DONE entry and held until the next DONE.
module mult_32bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_32bit_seq_if.slave       bus,
  output mul_state_t            dbg_state
);

  mul_state_t         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] product_r;
  logic [2*WIDTH-1:0] step_val;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;
  logic               load;
  logic               step;

  assign load = ready_r & bus.start;
  assign step = (state == CALC);

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .a        (bus.a),
    .b        (bus.b),
    .step_val (step_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      product_r <= '0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= CALC;
            count   <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          // Final step: capture the value the accumulator takes on this edge
          if (count == CNT_W'(WIDTH-1)) begin
            state     <= DONE;
            product_r <= step_val;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state   <= CALC;
            count   <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Directed and random checks of mult_32bit_seq against a plain a*b reference.
module tb_mult_32bit_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  mul_state_t dbg_state;

  mult_32bit_seq_if #(.WIDTH(32)) bus ();

  mult_32bit_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_product = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_product"}, bus.product, 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // One-cycle start pulse; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(64'(a) * 64'(b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Observes cycles n=0..33 after acceptance; optionally pokes start at ignore_at.
  task automatic finish_op(input string tag, input int ignore_at);
    int          done_n   = -1;
    int          done_cnt = 0;
    int          busy_err = 0;
    int          hold_err = 0;
    logic [63:0] got      = '0;
    logic [63:0] exp;
    for (int n = 0; n <= 33; n++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (bus.busy !== (n < 32)) busy_err++;
      if (n < 32 && bus.product !== last_product) hold_err++;
      if (n == 32) got = bus.product;
      if (n == ignore_at) begin
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check({tag, "_done_cycle"}, 64'(done_n + 1), 64'(MUL_LATENCY));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy"}, 64'(busy_err), 64'd0);
    check({tag, "_hold"}, 64'(hold_err), 64'd0);
    check({tag, "_product"}, got, exp);
    last_product = exp;
  endtask

  initial begin
    int          d_first;
    int          d_second;
    int          d_cnt;
    int          hold_err;
    logic [63:0] p_second;
    logic [31:0] ra;
    logic [31:0] rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check_idle_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    start_op(32'd7, 32'd6);
    finish_op("small", -1);
    check("small_literal", last_product, 64'h2A);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("maxmax", -1);
    check("maxmax_literal", last_product, 64'hFFFF_FFFE_0000_0001);

    start_op(32'h8000_0000, 32'd2);
    finish_op("msb_x2", -1);

    start_op(32'd0, 32'hDEAD_BEEF);
    finish_op("zero", -1);

    start_op(32'd1234, 32'd5678);
    finish_op("ignored_start", 10);

    // Back-to-back: start held high, operands switch after the first accept
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    @(negedge clk);
    bus.a    = 32'd9;
    bus.b    = 32'd9;
    d_first  = -1;
    d_second = -1;
    d_cnt    = 0;
    hold_err = 0;
    p_second = '0;
    for (int n = 0; n <= 70; n++) begin
      if (bus.done === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = n;
        else if (d_second < 0) d_second = n;
      end
      if (n >= 32 && n < 65 && bus.product !== 64'd12) hold_err++;
      if (n == 65) begin
        p_second  = bus.product;
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_first_done", 64'(d_first + 1), 64'd33);
    check("b2b_second_done", 64'(d_second + 1), 64'd66);
    check("b2b_done_count", 64'(d_cnt), 64'd2);
    check("b2b_hold12", 64'(hold_err), 64'd0);
    check("b2b_product81", p_second, 64'd81);
    last_product = 64'd81;

    // Abort mid-calculation with an asynchronous reset away from any edge
    start_op(32'd123, 32'd456);
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_product = '0;
    d_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) d_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(d_cnt), 64'd0);
    start_op(32'd123, 32'd456);
    finish_op("after_abort", -1);
    check("after_abort_literal", last_product, 64'd56088);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'hFFFF_FFFF;
      start_op(ra, rb);
      finish_op("random", (i % 2 == 1) ? int'($urandom_range(0, 31)) : -1);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_32bit_seq.md
Name: mult_32bit_seq

Overview:
- Sequential unsigned 32x32 -> 64 shift-add multiplier for the 32-bit ALU.
- The ALU's bitwise units (and/or/xor/nor) are single-cycle combinational producers. This block is the multi-cycle counterpart: it accepts operands on a start handshake, iterates one multiplier bit per clock, and returns the product with a done pulse.
- The ALU top-level mux selects `product[31:0]` for MUL and `product[63:32]` for MULH.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- ready  output  1  1 in IDLE or DONE; start may be accepted
- busy  output  1  1 while in CALC
- done  output  1  one-cycle pulse; product valid and stable
- product  output  2*WIDTH  result; held until next accepted start

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, count=0, product=0.
  - done=0, busy=0, ready=1.
  - Internal multiplicand register = 0; accumulator/multiplier shift register = 0.
- States:
  - IDLE -> CALC on start.
  - CALC -> DONE when count reaches WIDTH-1 on the current edge.
  - DONE -> CALC on start; DONE -> IDLE otherwise.
- Accepted start (edge E0):
  - Latch a into mcand.
  - Load acc = {WIDTH+1 zeros, b}.
  - count=0, state=CALC.
- Each CALC edge:
  - If acc[0]=1, upper part = acc[2W:W] + {1'b0, mcand}, a (WIDTH+1)-bit add with the carry kept; else the upper part is unchanged.
  - Then acc shifts right 1 with zero fill; count increments.
- Latency:
  - WIDTH CALC edges (E1..E32).
  - State is DONE after E32, and product = acc[2W-1:0] is registered on that edge.
  - done=1 for exactly the cycle after E32, i.e. 33 cycles after the accepting edge.
- done, busy and ready are decoded from registered state; there are no combinational paths from inputs to outputs.
- start while busy=1 is ignored: no restart and operands are not re-latched. a and b may change freely during CALC.
- start during the DONE cycle is accepted (back-to-back operation). done still pulses for exactly one cycle; product updates only at the next DONE.
- product holds its last value through IDLE and throughout the next CALC. It changes only on the DONE-entry edge.
- reset asserted mid-CALC aborts the operation, with no done pulse. The first start after reset deasserts behaves as a fresh operation.
- Arithmetic is unsigned only, with no overflow possible. 0 x anything = 0 (still takes full latency). Latency is fixed, with no early termination.

Decomposition:
- Shared alu_pkg holds:
  - mul_state_t enum: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - MUL_LATENCY = WIDTH+1.
  - The ALU opcode constants for MUL/MULH used by the top mux.
- One sub-module is natural: mult_datapath, holding mcand, acc, the (WIDTH+1)-bit adder and the shifter.
  - Controls: load, step.
  - The FSM and counter stay in mult_32bit_seq.

Test Plan:
1. Reset: reset high mid-sim, asynchronously with no clock edge -> product=0, done=0, busy=0, ready=1 immediately.
2. Small product: a=7, b=6, start for 1 cycle -> busy=1 for 32 cycles, done=1 on cycle 33 only, product=64'h2A.
3. Max operands: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001. Also a=32'h80000000, b=2 -> 64'h1_00000000.
4. Ignored start: start pulsed at cycle 10 of CALC with a=5, b=5 -> original result returned; done exactly once; no extra latency.
5. Back-to-back and hold: start held high continuously with 3x4 then 9x9 -> done pulses at cycles 33 and 66, product 12 then 81. Product stays 12 between the two pulses.
6. Abort: reset asserted at cycle 15 of a 123x456 operation -> no done pulse. A following 123x456 run yields 56088 after 33 cycles.
